// File: rtl/dfr_pkg.sv
// Shared types and constants for the DFR batch sequencer slice.
package dfr_pkg;

  // Cycles from input-memory read address to history write: the DRAIN
  // length and the hist_wen/hist_addr delay both derive from this.
  localparam int unsigned DFR_PIPE_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    RES_RST,
    RUN,
    DRAIN,
    MM_START,
    MM_WAIT,
    NEXT,
    ABORT
  } dfr_seq_state_t;

endpackage

// File: rtl/dfr_batch_sequencer_if.sv
// Datapath-side signals of the batch sequencer: input/history memory
// addressing, reservoir control and matrix-multiplier handshake.
interface dfr_batch_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  reservoir_rst;
  logic                  reservoir_en;
  logic [ADDR_WIDTH-1:0] hist_addr;
  logic                  hist_wen;
  logic                  mm_rst;
  logic                  mm_start;
  logic                  mm_busy;

  modport master (
    output in_addr, reservoir_rst, reservoir_en, hist_addr, hist_wen,
    output mm_rst, mm_start,
    input  mm_busy
  );

  modport slave (
    input  in_addr, reservoir_rst, reservoir_en, hist_addr, hist_wen,
    input  mm_rst, mm_start,
    output mm_busy
  );
endinterface

// File: rtl/dfr_perf_counter.sv
// Saturating busy-cycle counter used by the batch sequencer when
// DFR_SEQ_PERF_CNT_EN is defined.
module dfr_perf_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles, clear on request, stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dfr_batch_sequencer.sv
// DFR batch sequencer: walks the input memory sample by sample, drives the
// reservoir, records its outputs into history memory and runs the matrix
// multiplier once per sample.
// Optional feature: define DFR_SEQ_PERF_CNT_EN to add the 32-bit
// cycle_count output (busy-cycle counter).
module dfr_batch_sequencer
  import dfr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned MM_TIMEOUT   = 4096
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    start,
  input  logic                    abort,
  input  logic [SAMPLE_WIDTH-1:0] num_samples,
  input  logic [ADDR_WIDTH-1:0]   num_steps,
  dfr_batch_sequencer_if.master   dp,
  output logic [SAMPLE_WIDTH-1:0] sample_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    err
`ifdef DFR_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]             cycle_count
`endif
);

  localparam int unsigned WAIT_W = $clog2(MM_TIMEOUT + 1);

  dfr_seq_state_t                           state, state_d;
  logic                                     start_armed;
  logic                                     accept, launch, done_d, err_set, flush;
  logic [SAMPLE_WIDTH-1:0]                  ns_q;
  logic [ADDR_WIDTH-1:0]                    nsteps_q;
  logic [ADDR_WIDTH-1:0]                    in_ptr;
  logic [ADDR_WIDTH-1:0]                    step_cnt;
  logic [WAIT_W-1:0]                        wait_cnt;
  logic                                     mm_seen;
  logic                                     en_q;
  logic [DFR_PIPE_LAT-1:0]                  wen_pipe;
  logic [DFR_PIPE_LAT-1:0][ADDR_WIDTH-1:0]  addr_pipe;

  // start_armed means "start was low last cycle"; clearing it in reset
  // makes a start held through reset look like no edge at all.
  assign accept = (state == IDLE) && !abort && start && start_armed;

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_d = state;
    launch  = 1'b0;
    done_d  = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (num_samples == '0) begin
            done_d = 1'b1;
          end else if (num_steps == '0) begin
            done_d  = 1'b1;
            err_set = 1'b1;
          end else begin
            launch  = 1'b1;
            state_d = RES_RST;
          end
        end
      end
      RES_RST:  state_d = RUN;
      RUN:      if (step_cnt == nsteps_q - 1'b1) state_d = DRAIN;
      DRAIN:    if (step_cnt == ADDR_WIDTH'(DFR_PIPE_LAT - 1)) state_d = MM_START;
      MM_START: state_d = MM_WAIT;
      MM_WAIT: begin
        if (mm_seen && !dp.mm_busy) begin
          state_d = NEXT;
        end else if (!mm_seen && !dp.mm_busy &&
                     (wait_cnt == WAIT_W'(MM_TIMEOUT - 1))) begin
          err_set = 1'b1;
          state_d = ABORT;
        end
      end
      NEXT: begin
        if (sample_idx == ns_q - 1'b1) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RES_RST;
        end
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state != IDLE) && (state != ABORT)) begin
      state_d = ABORT;
      done_d  = 1'b0;
      err_set = 1'b0;
    end
  end

  assign flush = (state_d == ABORT);

  // State, counters, status flags and the read-to-write pipeline.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state       <= IDLE;
      start_armed <= 1'b0;
      ns_q        <= '0;
      nsteps_q    <= '0;
      in_ptr      <= '0;
      step_cnt    <= '0;
      wait_cnt    <= '0;
      mm_seen     <= 1'b0;
      sample_idx  <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      en_q        <= 1'b0;
      wen_pipe    <= '0;
      addr_pipe   <= '0;
    end else begin
      state       <= state_d;
      start_armed <= !start;
      done        <= done_d;

      if (err_set) begin
        err <= 1'b1;
      end else if (launch) begin
        err <= 1'b0;
      end

      if (launch) begin
        ns_q       <= num_samples;
        nsteps_q   <= num_steps;
        sample_idx <= '0;
        in_ptr     <= '0;
      end else if (state == RUN) begin
        in_ptr <= in_ptr + 1'b1;
      end

      // One counter serves RUN (step index) and DRAIN (flush cycles).
      if (state != state_d) begin
        step_cnt <= '0;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end

      if (state == MM_START) begin
        wait_cnt <= WAIT_W'(1);
        mm_seen  <= 1'b0;
      end else if (state == MM_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (dp.mm_busy) mm_seen <= 1'b1;
      end

      if ((state == NEXT) && (state_d == RES_RST)) begin
        sample_idx <= sample_idx + 1'b1;
      end

      en_q         <= (state == RUN) && !flush;
      wen_pipe[0]  <= (state == RUN);
      addr_pipe[0] <= step_cnt;
      for (int unsigned i = 1; i < DFR_PIPE_LAT; i++) begin
        wen_pipe[i]  <= wen_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
      // Reads already in flight when aborting must not land in history.
      if (flush) wen_pipe <= '0;
    end
  end

  // Output decode from state and pipeline registers.
  always_comb begin
    dp.in_addr       = in_ptr;
    dp.reservoir_rst = (state == RES_RST) || (state == ABORT);
    dp.mm_rst        = (state == RES_RST) || (state == ABORT);
    dp.mm_start      = (state == MM_START);
    dp.reservoir_en  = en_q;
    dp.hist_wen      = wen_pipe[DFR_PIPE_LAT-1];
    dp.hist_addr     = addr_pipe[DFR_PIPE_LAT-1];
    busy             = (state != IDLE);
  end

`ifdef DFR_SEQ_PERF_CNT_EN
  dfr_perf_counter #(
    .WIDTH (32)
  ) u_perf (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .clear (accept),
    .en    (busy),
    .count (cycle_count)
  );
`endif

endmodule

// File: tb/tb_dfr_batch_sequencer.sv
// Self-checking bench for dfr_batch_sequencer: directed and randomized
// batches against a reference model of the batch schedule.
module tb_dfr_batch_sequencer;

  localparam int unsigned AW  = 5;
  localparam int unsigned SW  = 16;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] num_samples = '0;
  logic [AW-1:0] num_steps = '0;
  logic [SW-1:0] sample_idx;
  logic          busy, done, err;
`ifdef DFR_SEQ_PERF_CNT_EN
  logic [31:0]   cycle_count;
`endif

  dfr_batch_sequencer_if #(.ADDR_WIDTH(AW)) dp ();

  dfr_batch_sequencer #(
    .ADDR_WIDTH   (AW),
    .SAMPLE_WIDTH (SW),
    .MM_TIMEOUT   (TMO)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstn),
    .start         (start),
    .abort         (abort),
    .num_samples   (num_samples),
    .num_steps     (num_steps),
    .dp            (dp),
    .sample_idx    (sample_idx),
    .busy          (busy),
    .done          (done),
    .err           (err)
`ifdef DFR_SEQ_PERF_CNT_EN
    ,
    .cycle_count   (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Matrix multiplier model: busy rises mm_d cycles after mm_start and
  // stays high for mm_l cycles; with mm_on=0 it never responds.
  logic mm_busy_m = 1'b0;
  int   mm_phase = 0, mm_cnt = 0, mm_d = 1, mm_l = 1;
  bit   mm_on = 1'b1;
  assign dp.mm_busy = mm_busy_m;

  always @(posedge clk) begin
    #1;
    case (mm_phase)
      0: if (dp.mm_start && mm_on) begin mm_phase = 1; mm_cnt = mm_d; end
      1: begin
        mm_cnt--;
        if (mm_cnt == 0) begin mm_busy_m = 1'b1; mm_phase = 2; mm_cnt = mm_l; end
      end
      default: begin
        mm_cnt--;
        if (mm_cnt == 0) begin mm_busy_m = 1'b0; mm_phase = 0; end
      end
    endcase
  end

  // Event log gathered mid-cycle.
  logic [AW-1:0] rd_addr[$], wr_addr[$], prev_in_addr = '0;
  int rd_cyc[$], wr_cyc[$];
  int n_mmstart, n_done, n_busy, n_rrst, n_mrst;
  int first_busy, last_busy, done_cyc, mmstart_cyc, rrst_cyc, err_rise_cyc;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (dp.reservoir_en) begin rd_addr.push_back(prev_in_addr); rd_cyc.push_back(cyc); end
    prev_in_addr = dp.in_addr;
    if (dp.hist_wen) begin wr_addr.push_back(dp.hist_addr); wr_cyc.push_back(cyc); end
    if (dp.mm_start) begin n_mmstart++; mmstart_cyc = cyc; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (busy) begin n_busy++; if (first_busy < 0) first_busy = cyc; last_busy = cyc; end
    if (dp.reservoir_rst) begin n_rrst++; rrst_cyc = cyc; end
    if (dp.mm_rst) n_mrst++;
    if (err && !err_prev) err_rise_cyc = cyc;
    err_prev = err;
  end

  task automatic clear_log();
    rd_addr.delete(); wr_addr.delete(); rd_cyc.delete(); wr_cyc.delete();
    n_mmstart = 0; n_done = 0; n_busy = 0; n_rrst = 0; n_mrst = 0;
    first_busy = -1; last_busy = -1; done_cyc = -1; mmstart_cyc = -1;
    rrst_cyc = -1; err_rise_cyc = -1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int s_cyc;

  task automatic launch(input int ns, input int n);
    @(negedge clk);
    num_samples = SW'(ns);
    num_steps   = AW'(n);
    @(negedge clk);
    #1;
    clear_log();
    start = 1'b1;
    s_cyc = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    repeat (3) @(negedge clk);
    while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    check("idle_within_budget", (k < budget), 1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_mm_quiet();
    int k = 0;
    while (mm_phase != 0 && k < 200) begin @(negedge clk); k++; end
    check("mm_model_quiet", (k < 200), 1);
  endtask

  // Full batch with every result derived from the schedule rules.
  task automatic do_batch(input int ns, input int n, input int d, input int l);
    int bad;
    mm_on = 1'b1; mm_d = d; mm_l = l;
    launch(ns, n);
    wait_idle(2000);
    start = 1'b0;
    check("rd_count", rd_addr.size(), ns * n);
    for (int i = 0; i < rd_addr.size() && i < ns * n; i++)
      check("in_addr", rd_addr[i], i % (1 << AW));
    check("hist_count", wr_addr.size(), ns * n);
    for (int i = 0; i < wr_addr.size() && i < ns * n; i++)
      check("hist_addr", wr_addr[i], i % n);
    bad = 0;
    for (int i = 0; i < wr_cyc.size() && i < rd_cyc.size(); i++)
      if (wr_cyc[i] != rd_cyc[i] + 1) bad++;
    check("hist_latency_bad", bad, 0);
    if (rd_cyc.size() > 0) check("first_read_cycle", rd_cyc[0], s_cyc + 3);
    check("first_busy_cycle", first_busy, s_cyc + 1);
    check("busy_cycles", n_busy, ns * (n + 5 + d + l));
    check("mm_start_pulses", n_mmstart, ns);
    check("reservoir_rst_pulses", n_rrst, ns);
    check("mm_rst_pulses", n_mrst, ns);
    check("done_pulses", n_done, 1);
    check("done_after_busy", done_cyc, last_busy + 1);
    check("err_clear", err, 0);
    check("sample_idx_final", sample_idx, ns - 1);
    check("busy_end", busy, 0);
`ifdef DFR_SEQ_PERF_CNT_EN
    check("cycle_count", cycle_count, n_busy);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_log();
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          {dp.in_addr, dp.hist_addr, dp.reservoir_rst, dp.reservoir_en, dp.hist_wen,
           dp.mm_rst, dp.mm_start, sample_idx, busy, done, err}, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Zero samples: done next cycle, never busy.
    launch(0, 4);
    wait_idle(50);
    start = 1'b0;
    check("ns0_done", n_done, 1);
    check("ns0_done_cycle", done_cyc, s_cyc + 1);
    check("ns0_busy", n_busy, 0);
    check("ns0_err", err, 0);

    // Zero steps: done with error.
    launch(2, 0);
    wait_idle(50);
    start = 1'b0;
    check("nsteps0_done", n_done, 1);
    check("nsteps0_done_cycle", done_cyc, s_cyc + 1);
    check("nsteps0_busy", n_busy, 0);
    check("nsteps0_err", err, 1);

    // Reference batch; launch also clears the sticky error.
    do_batch(3, 4, 1, 10);
    // Pointer wrap inside one batch.
    do_batch(3, 12, 2, 3);
    for (int r = 0; r < 4; r++)
      do_batch($urandom_range(1, 3), $urandom_range(1, 14),
               $urandom_range(1, 3), $urandom_range(1, 12));

    // Multiplier never answers.
    mm_on = 1'b0;
    launch(1, 3);
    wait_idle(500);
    start = 1'b0;
    check("tmo_err", err, 1);
    check("tmo_err_cycle", err_rise_cyc, mmstart_cyc + TMO);
    check("tmo_abort_rst_cycle", rrst_cyc, mmstart_cyc + TMO);
    check("tmo_rst_pulses", n_rrst, 2);
    check("tmo_mm_rst_pulses", n_mrst, 2);
    check("tmo_done", n_done, 0);
    check("tmo_busy_cycles", n_busy, 3 + TMO + 4);
    mm_on = 1'b1;

    // Abort in RUN of sample 1.
    begin
      int k = 0;
      mm_d = 1; mm_l = 3;
      launch(3, 4);
      while (!(dp.reservoir_rst === 1'b1 && sample_idx == 1) && k < 200) begin
        @(negedge clk); k++;
      end
      check("abort_reach_sample1", (k < 200), 1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      #1;
      check("abort_state_rst", {dp.reservoir_rst, dp.mm_rst, busy}, 3'b111);
      abort = 1'b0;
      @(negedge clk);
      #1;
      check("abort_idle", busy, 0);
      check("abort_sample_idx", sample_idx, 1);
      repeat (5) @(negedge clk);
      #1;
      check("abort_no_done", n_done, 0);
      check("abort_no_relaunch", n_busy, (4 + 5 + 1 + 3) + 3);
      check("abort_err", err, 0);
      start = 1'b0;
    end

    // Abort beats a start edge in IDLE.
    @(negedge clk);
    #1;
    clear_log();
    abort = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort_start_busy", n_busy, 0);
    check("abort_start_done", n_done, 0);
    start = 1'b0;

    // Reset mid-batch in MM_WAIT.
    begin
      int k = 0;
      mm_d = 2; mm_l = 10;
      launch(1, 4);
      while (mm_busy_m !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      check("rst_reach_mm_wait", (k < 200), 1);
      rstn = 1'b0;
      @(negedge clk);
      #1;
      check("rst_mid_outputs",
            {dp.in_addr, dp.hist_addr, dp.reservoir_rst, dp.reservoir_en, dp.hist_wen,
             dp.mm_rst, dp.mm_start, sample_idx, busy, done, err}, 0);
      rstn = 1'b1;
      clear_log();
      repeat (4) @(negedge clk);
      #1;
      check("rst_start_held_no_launch", n_busy, 0);
      start = 1'b0;
      wait_mm_quiet();
    end
    do_batch(1, 4, 1, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
